// File: rtl/audio_proc_pkg.sv
// audio_proc_pkg: shared mode constants, FSM states and saturating add for the echo processor
package audio_proc_pkg;
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ECHO = 2'b01;
    localparam logic [1:0] MODE_MUTE = 2'b10;
    localparam int MAX_W = 64;

    typedef enum logic [2:0] {CLEAR, IDLE, FETCH, CALC, WAIT_WR} state_t;

    typedef struct packed {
        logic             clip;
        logic [MAX_W-1:0] y;
    } sat_t;

    // Operands arrive sign-extended to MAX_W; the sum is clamped to a w-bit signed range.
    function automatic sat_t sat_add(input logic signed [MAX_W-1:0] a, input logic signed [MAX_W-1:0] b, input int w);
        logic signed [MAX_W:0] s, hi, lo, one;
        one = 1;
        s = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        hi = (one <<< (w - 1)) - one;
        lo = -hi - one;
        sat_add.clip = (s > hi) || (s < lo);
        sat_add.y = s > hi ? hi[MAX_W-1:0] : s < lo ? lo[MAX_W-1:0] : s[MAX_W-1:0];
    endfunction
endpackage

// File: rtl/echo_delay_ram.sv
// echo_delay_ram: simple dual-port synchronous RAM, one-cycle read latency, contents not reset
module echo_delay_ram #(
    parameter int W = 48,
    parameter int DEPTH = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/audio_echo_proc.sv
// audio_echo_proc: stereo passthrough / feedback echo / mute between codec read and write handshakes,
// with output saturation, clip reporting and a delay-line clear after every reset.
module audio_echo_proc
    import audio_proc_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [2:0]        atten,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              clip
);
    state_t state, state_n;
    logic [ADDR_W-1:0] ptr, clr_addr, ram_waddr;
    logic signed [DATA_W-1:0] x_l, x_r, y_l, y_r, d_l, d_r, sh_l, sh_r;
    logic [1:0] mode_q;
    logic [2:0] atten_q;
    logic flag, ram_we;
    logic [2*DATA_W-1:0] rd_data, ram_wdata;
    sat_t s_l, s_r;
    logic sat_hi_unused;

    assign ram_we = state == CLEAR || (state == WAIT_WR && write_ready);
    assign ram_waddr = state == CLEAR ? clr_addr : ptr;
    assign ram_wdata = state == CLEAR ? '0 : {y_l, y_r};

    echo_delay_ram #(.W(2*DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk(CLOCK_50),
        .we(ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ptr),
        .rdata(rd_data)
    );

    assign d_l = rd_data[2*DATA_W-1:DATA_W];
    assign d_r = rd_data[DATA_W-1:0];
    assign sh_l = d_l >>> atten_q;
    assign sh_r = d_r >>> atten_q;
    assign s_l = sat_add(MAX_W'(x_l), MAX_W'(sh_l), DATA_W);
    assign s_r = sat_add(MAX_W'(x_r), MAX_W'(sh_r), DATA_W);
    // Clamped results are sign-extended, so bits above DATA_W carry no information.
    assign sat_hi_unused = ^{s_l.y[MAX_W-1:DATA_W], s_r.y[MAX_W-1:DATA_W]};

    always_comb begin
        state_n = state;
        case (state)
            CLEAR:   state_n = clr_addr == ADDR_W'(DEPTH - 1) ? IDLE : CLEAR;
            IDLE:    state_n = read_ready ? FETCH : IDLE;
            FETCH:   state_n = CALC;
            CALC:    state_n = WAIT_WR;
            WAIT_WR: state_n = write_ready ? IDLE : WAIT_WR;
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr <= '0;
            clr_addr <= '0;
            busy <= 1'b1;
            read <= 1'b0;
            write <= 1'b0;
            clip <= 1'b0;
            writedata_left <= '0;
            writedata_right <= '0;
            x_l <= '0;
            x_r <= '0;
            y_l <= '0;
            y_r <= '0;
            mode_q <= MODE_PASS;
            atten_q <= '0;
            flag <= 1'b0;
        end else begin
            state <= state_n;
            read <= 1'b0;
            write <= 1'b0;
            clip <= 1'b0;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == ADDR_W'(DEPTH - 1))
                    busy <= 1'b0;
            end
            if (state == IDLE && read_ready) begin
                x_l <= readdata_left;
                x_r <= readdata_right;
                mode_q <= mode;
                atten_q <= atten;
                read <= 1'b1;
            end
            if (state == CALC) begin
                y_l <= mode_q == MODE_PASS ? x_l : mode_q == MODE_ECHO ? s_l.y[DATA_W-1:0] : '0;
                y_r <= mode_q == MODE_PASS ? x_r : mode_q == MODE_ECHO ? s_r.y[DATA_W-1:0] : '0;
                flag <= mode_q == MODE_ECHO && (s_l.clip || s_r.clip);
            end
            if (state == WAIT_WR && write_ready) begin
                writedata_left <= y_l;
                writedata_right <= y_r;
                write <= 1'b1;
                clip <= flag;
                ptr <= ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_echo_proc.sv
// tb_audio_echo_proc: directed checks of clear, passthrough, echo, saturation, back-pressure and mid-reset
module tb_audio_echo_proc;
    localparam int DW = 24;
    localparam int DP = 8;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [2:0] atten = 3'd0;
    logic read_ready = 1'b0;
    logic write_ready = 1'b0;
    logic [DW-1:0] readdata_left = '0;
    logic [DW-1:0] readdata_right = '0;
    logic read, write, busy, clip;
    logic [DW-1:0] writedata_left, writedata_right;

    int total = 0;
    int bad = 0;
    int n_reads = 0;
    int n_writes = 0;
    int overlap = 0;

    audio_echo_proc #(.DATA_W(DW), .DEPTH(DP)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .mode(mode),
        .atten(atten),
        .read_ready(read_ready),
        .write_ready(write_ready),
        .readdata_left(readdata_left),
        .readdata_right(readdata_right),
        .read(read),
        .write(write),
        .writedata_left(writedata_left),
        .writedata_right(writedata_right),
        .busy(busy),
        .clip(clip)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (read === 1'b1) n_reads <= n_reads + 1;
        if (write === 1'b1) n_writes <= n_writes + 1;
        if (read === 1'b1 && write === 1'b1) overlap <= overlap + 1;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_write(input string tag);
        int t = 0;
        while (write !== 1'b1 && t < 60) begin tick(); t++; end
        if (write !== 1'b1) begin total++; bad++; $display("FAIL %s write_timeout got=%b want=1", tag, write); end
    endtask

    // Pulse reset, then report how many cycles busy stayed high.
    task automatic do_reset(output int busy_cycles);
        read_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 40) begin tick(); busy_cycles++; end
    endtask

    task automatic do_sample(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic [1:0] md,
                             input logic [2:0] at, output logic [DW-1:0] ol, output logic [DW-1:0] orr,
                             output logic oc, output int lat);
        int t = 0;
        readdata_left = l;
        readdata_right = r;
        mode = md;
        atten = at;
        write_ready = 1'b1;
        read_ready = 1'b1;
        while (read !== 1'b1 && t < 60) begin tick(); t++; end
        if (read !== 1'b1) begin total++; bad++; $display("FAIL sample read_timeout got=%b want=1", read); end
        read_ready = 1'b0;
        lat = 0;
        while (write !== 1'b1 && lat < 60) begin tick(); lat++; end
        if (write !== 1'b1) begin total++; bad++; $display("FAIL sample write_timeout got=%b want=1", write); end
        ol = writedata_left;
        orr = writedata_right;
        oc = clip;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        read_ready = 1'b1;
        write_ready = 1'b1;
        tick();
        tick();
        total++; if (writedata_left !== '0 || writedata_right !== '0 || clip !== 1'b0) begin bad++; $display("FAIL reset_outputs got=%h/%h/%b want=0/0/0", writedata_left, writedata_right, clip); end
        reset = 1'b0;
        for (int i = 0; i < DP; i++) begin
            total++; if (busy !== 1'b1 || read !== 1'b0 || write !== 1'b0) begin bad++; $display("FAIL clear_cycle%0d got busy=%b read=%b write=%b want 1/0/0", i, busy, read, write); end
            tick();
        end
        total++; if (busy !== 1'b0 || read !== 1'b0) begin bad++; $display("FAIL clear_done got busy=%b read=%b want 0/0", busy, read); end
        tick();
        total++; if (read !== 1'b1) begin bad++; $display("FAIL first_read got=%b want=1", read); end
        read_ready = 1'b0;
        wait_write("first_sample");
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] ol, orr;
        logic oc;
        int lat;
        do_sample(24'h000100, 24'hFFFF00, 2'b00, 3'd0, ol, orr, oc, lat);
        total++; if (ol !== 24'h000100) begin bad++; $display("FAIL pass_left got=%h want=000100", ol); end
        total++; if (orr !== 24'hFFFF00) begin bad++; $display("FAIL pass_right got=%h want=FFFF00", orr); end
        total++; if (lat !== 3) begin bad++; $display("FAIL pass_latency got=%0d want=3", lat); end
        total++; if (oc !== 1'b0) begin bad++; $display("FAIL pass_clip got=%b want=0", oc); end
    endtask

    task automatic test_echo_impulse();
        logic [DW-1:0] ol, orr, exp_l;
        logic oc;
        int lat, bc;
        do_reset(bc);
        for (int i = 0; i < 17; i++) begin
            do_sample(i == 0 ? 24'h100000 : 24'h000000, 24'h000000, 2'b01, 3'd1, ol, orr, oc, lat);
            exp_l = i == 0 ? 24'h100000 : i == 8 ? 24'h080000 : i == 16 ? 24'h040000 : 24'h000000;
            total++; if (ol !== exp_l || orr !== 24'h0) begin bad++; $display("FAIL echo_s%0d got=%h/%h want=%h/000000", i, ol, orr, exp_l); end
        end
    endtask

    task automatic test_clip();
        logic [DW-1:0] ol, orr;
        logic oc;
        int lat, bc;
        do_reset(bc);
        for (int i = 0; i < 9; i++) begin
            do_sample(24'h7FFFFF, 24'h800000, 2'b01, 3'd0, ol, orr, oc, lat);
            total++; if (ol !== 24'h7FFFFF || orr !== 24'h800000) begin bad++; $display("FAIL clip_s%0d_data got=%h/%h want=7FFFFF/800000", i, ol, orr); end
            total++; if (oc !== (i == 8)) begin bad++; $display("FAIL clip_s%0d_flag got=%b want=%b", i, oc, i == 8); end
        end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] ol, orr;
        logic oc;
        int lat, r0, w0, t;
        do_sample(24'h000100, 24'hFFFF00, 2'b00, 3'd0, ol, orr, oc, lat);
        tick();
        r0 = n_reads;
        w0 = n_writes;
        readdata_left = 24'h123456;
        readdata_right = 24'h654321;
        mode = 2'b00;
        write_ready = 1'b0;
        read_ready = 1'b1;
        t = 0;
        while (read !== 1'b1 && t < 60) begin tick(); t++; end
        total++; if (read !== 1'b1) begin bad++; $display("FAIL bp_read got=%b want=1", read); end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (write !== 1'b0 || read !== 1'b0 || writedata_left !== 24'h000100) begin bad++; $display("FAIL bp_hold%0d got write=%b read=%b wl=%h want 0/0/000100", i, write, read, writedata_left); end
        end
        total++; if (n_reads - r0 !== 1) begin bad++; $display("FAIL bp_reads got=%0d want=1", n_reads - r0); end
        write_ready = 1'b1;
        wait_write("bp");
        read_ready = 1'b0;
        total++; if (writedata_left !== 24'h123456 || writedata_right !== 24'h654321) begin bad++; $display("FAIL bp_data got=%h/%h want=123456/654321", writedata_left, writedata_right); end
        tick();
        total++; if (n_writes - w0 !== 1 || n_reads - r0 !== 1) begin bad++; $display("FAIL bp_counts got reads=%0d writes=%0d want 1/1", n_reads - r0, n_writes - w0); end
    endtask

    task automatic test_reset_in_calc();
        logic [DW-1:0] ol, orr;
        logic oc;
        int lat, bc, w0, t;
        do_reset(bc);
        for (int i = 0; i < 3; i++)
            do_sample(24'h400000, 24'h400000, 2'b01, 3'd0, ol, orr, oc, lat);
        readdata_left = 24'h400000;
        readdata_right = 24'h400000;
        write_ready = 1'b1;
        read_ready = 1'b1;
        t = 0;
        while (read !== 1'b1 && t < 60) begin tick(); t++; end
        read_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++; if (read !== 1'b0 || write !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mid_reset got read=%b write=%b busy=%b want 0/0/1", read, write, busy); end
        w0 = n_writes;
        tick();
        tick();
        reset = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin tick(); bc++; end
        total++; if (bc !== DP) begin bad++; $display("FAIL mid_reset_busy got=%0d want=%0d", bc, DP); end
        total++; if (n_writes !== w0) begin bad++; $display("FAIL mid_reset_write got=%0d want=%0d", n_writes, w0); end
        for (int i = 0; i < 9; i++) begin
            do_sample(24'h0, 24'h0, 2'b01, 3'd0, ol, orr, oc, lat);
            total++; if (ol !== 24'h0 || orr !== 24'h0) begin bad++; $display("FAIL no_tail_s%0d got=%h/%h want=000000/000000", i, ol, orr); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_echo_impulse();
        test_clip();
        test_back_pressure();
        test_reset_in_calc();
        total++; if (overlap !== 0) begin bad++; $display("FAIL read_write_overlap got=%0d want=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
